// File: rtl/wordle_guess_encoder.sv
// Guess-word encoder: maps active-low 7-segment letter patterns back to letter
// indices and switch codes. Optional echo_segment output behind WORDLE_GUESS_ECHO_EN.
module wordle_guess_encoder #(
  parameter int WORD_LEN = 5,
  parameter int CW       = $clog2(WORD_LEN + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    seg_valid,
  output logic                    seg_ready,
  input  logic [6:0]              seg_pattern,
  input  logic                    backspace,
  input  logic                    clear,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic [5*WORD_LEN-1:0]   word_letters,
  output logic [10*WORD_LEN-1:0]  word_switch,
  output logic [CW-1:0]           letter_count,
  output logic                    bad_pattern,
`ifdef WORDLE_GUESS_ECHO_EN
  output logic [6:0]              echo_segment,
`endif
  output logic                    dbg_state
);

  localparam int IW = $clog2(WORD_LEN);

  // Both ports use valid/ready: a transfer happens on a rising edge where
  // valid && ready; word_valid is held with stable data until that transfer
  // (only clear may withdraw it).
  typedef enum logic {ST_COLLECT = 1'b0, ST_PRESENT = 1'b1} state_t;

  state_t                   r_state, w_state_nxt;
  logic [CW-1:0]            r_count, w_count_nxt;
  logic [WORD_LEN-1:0][4:0] r_slots, w_slots_nxt;
  logic                     r_bad, w_bad_nxt;
  logic                     w_pat_ok;
  logic [4:0]               w_pat_idx;
  logic [IW-1:0]            w_wr_idx, w_bs_idx;

  function automatic logic [9:0] sw_code(input logic [4:0] idx);
    logic [9:0] c;
    logic [3:0] b;
    c    = '0;
    b    = 4'd9 - 4'(idx % 5'd7);
    c[b] = 1'b1;
    case (idx / 5'd7)
      5'd0:    c[2:0] = 3'b000;
      5'd1:    c[2:0] = 3'b001;
      5'd2:    c[2:0] = 3'b010;
      default: c[2:0] = 3'b100;
    endcase
    return c;
  endfunction

  always_comb begin
    w_pat_ok  = 1'b1;
    w_pat_idx = 5'd0;
    case (seg_pattern)
      7'b0001000: w_pat_idx = 5'd0;
      7'b1100000: w_pat_idx = 5'd1;
      7'b0110001: w_pat_idx = 5'd2;
      7'b1000010: w_pat_idx = 5'd3;
      7'b0110000: w_pat_idx = 5'd4;
      7'b0111000: w_pat_idx = 5'd5;
      7'b0000100: w_pat_idx = 5'd6;
      7'b1101000: w_pat_idx = 5'd7;
      7'b1001111: w_pat_idx = 5'd8;
      7'b1000111: w_pat_idx = 5'd9;
      7'b1111000: w_pat_idx = 5'd10;
      7'b1110001: w_pat_idx = 5'd11;
      7'b1101010: w_pat_idx = 5'd12;
      7'b1011010: w_pat_idx = 5'd13;
      7'b0000001: w_pat_idx = 5'd14;
      7'b0011000: w_pat_idx = 5'd15;
      7'b0001100: w_pat_idx = 5'd16;
      7'b1111010: w_pat_idx = 5'd17;
      7'b0100100: w_pat_idx = 5'd18;
      7'b1001110: w_pat_idx = 5'd19;
      7'b1000001: w_pat_idx = 5'd20;
      7'b1101011: w_pat_idx = 5'd21;
      7'b1001001: w_pat_idx = 5'd22;
      7'b1001000: w_pat_idx = 5'd23;
      7'b1000100: w_pat_idx = 5'd24;
      7'b0010010: w_pat_idx = 5'd25;
      default:    w_pat_ok  = 1'b0;
    endcase
  end

  assign w_wr_idx = IW'(r_count);
  assign w_bs_idx = IW'(r_count - CW'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_slots_nxt = r_slots;
    w_bad_nxt   = 1'b0;
    if (clear) begin
      w_state_nxt = ST_COLLECT;
      w_count_nxt = '0;
      w_slots_nxt = '0;
    end else if (r_state == ST_COLLECT) begin
      if (backspace) begin
        if (r_count != '0) begin
          w_count_nxt           = r_count - CW'(1);
          w_slots_nxt[w_bs_idx] = 5'd0;
        end
      end else if (seg_valid) begin
        if (w_pat_ok) begin
          w_slots_nxt[w_wr_idx] = w_pat_idx;
          w_count_nxt           = r_count + CW'(1);
          if (w_count_nxt == CW'(WORD_LEN)) w_state_nxt = ST_PRESENT;
        end else begin
          w_bad_nxt = 1'b1;
        end
      end
    end else if (word_ready) begin
      w_state_nxt = ST_COLLECT;
      w_count_nxt = '0;
      w_slots_nxt = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_COLLECT;
      r_count <= '0;
      r_slots <= '0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_slots <= w_slots_nxt;
      r_bad   <= w_bad_nxt;
    end
  end

  assign seg_ready    = (r_state == ST_COLLECT) && !backspace && !clear;
  assign word_valid   = (r_state == ST_PRESENT);
  assign word_letters = r_slots;
  assign letter_count = r_count;
  assign bad_pattern  = r_bad;
  assign dbg_state    = r_state;

  // Slot 0 (letter A) has a non-zero switch code, so empty slots are masked.
  for (genvar g = 0; g < WORD_LEN; g++) begin : g_sw
    assign word_switch[10*g +: 10] = (CW'(g) < r_count) ? sw_code(r_slots[g]) : 10'd0;
  end

`ifdef WORDLE_GUESS_ECHO_EN
  logic [6:0] r_echo;
  logic       w_echo_load, w_echo_blank;

  assign w_echo_blank = clear || ((r_state == ST_COLLECT) && backspace) ||
                        ((r_state == ST_PRESENT) && word_ready);
  assign w_echo_load  = seg_valid && seg_ready && w_pat_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)             r_echo <= 7'h7F;
    else if (w_echo_blank) r_echo <= 7'h7F;
    else if (w_echo_load)  r_echo <= seg_pattern;
  end

  assign echo_segment = r_echo;
`endif

endmodule

// File: tb/tb_wordle_guess_encoder.sv
// Bench for wordle_guess_encoder: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_wordle_guess_encoder;
  localparam int WL = 5;
  localparam int CW = $clog2(WL + 1);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              seg_valid = 1'b0;
  logic              seg_ready;
  logic [6:0]        seg_pattern = 7'h7F;
  logic              backspace = 1'b0;
  logic              clear = 1'b0;
  logic              word_valid;
  logic              word_ready = 1'b0;
  logic [5*WL-1:0]   word_letters;
  logic [10*WL-1:0]  word_switch;
  logic [CW-1:0]     letter_count;
  logic              bad_pattern;
  logic              dbg_state;
`ifdef WORDLE_GUESS_ECHO_EN
  logic [6:0]        echo_segment;
`endif

  wordle_guess_encoder #(.WORD_LEN(WL)) dut (
    .clock(clock), .reset(reset),
    .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_pattern(seg_pattern),
    .backspace(backspace), .clear(clear),
    .word_valid(word_valid), .word_ready(word_ready),
    .word_letters(word_letters), .word_switch(word_switch),
    .letter_count(letter_count), .bad_pattern(bad_pattern),
`ifdef WORDLE_GUESS_ECHO_EN
    .echo_segment(echo_segment),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [6:0] pat_tab [26] = '{
    7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000,
    7'b0000100, 7'b1101000, 7'b1001111, 7'b1000111, 7'b1111000, 7'b1110001,
    7'b1101010, 7'b1011010, 7'b0000001, 7'b0011000, 7'b0001100, 7'b1111010,
    7'b0100100, 7'b1001110, 7'b1000001, 7'b1101011, 7'b1001001, 7'b1001000,
    7'b1000100, 7'b0010010};

  // reference model
  int              m_q[$];
  bit              m_present;
  bit              m_bad;
  logic [6:0]      m_echo;
  logic [5*WL-1:0] exp_q[$];
  logic [5*WL-1:0] s_letters;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 26; i++) if (pat_tab[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [9:0] sw_of(input int i);
    logic [9:0] r;
    r = 10'd1 << (9 - i % 7);
    if (i / 7 > 0) r = r | (10'd1 << (i / 7 - 1));
    return r;
  endfunction

  function automatic logic [5*WL-1:0] m_letters();
    logic [5*WL-1:0] r;
    r = '0;
    for (int k = 0; k < m_q.size(); k++) r[5*k +: 5] = 5'(m_q[k]);
    return r;
  endfunction

  function automatic logic [10*WL-1:0] m_switch();
    logic [10*WL-1:0] r;
    r = '0;
    for (int k = 0; k < m_q.size(); k++) r[10*k +: 10] = sw_of(m_q[k]);
    return r;
  endfunction

  task automatic m_reset();
    m_q.delete();
    exp_q.delete();
    m_present = 1'b0;
    m_bad     = 1'b0;
    m_echo    = 7'h7F;
  endtask

  // One rising edge of the model, using the inputs currently driven.
  task automatic model_edge();
    int idx;
    m_bad = 1'b0;
    if (clear) begin
      m_q.delete();
      exp_q.delete();
      m_present = 1'b0;
      m_echo    = 7'h7F;
    end else if (!m_present) begin
      if (backspace) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
        m_echo = 7'h7F;
      end else if (seg_valid) begin
        idx = lookup(seg_pattern);
        if (idx < 0) m_bad = 1'b1;
        else begin
          m_q.push_back(idx);
          m_echo = seg_pattern;
          if (m_q.size() == WL) begin
            m_present = 1'b1;
            exp_q.push_back(m_letters());
          end
        end
      end
    end else if (word_ready) begin
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else chk("sb_word", s_letters, exp_q.pop_front());
      m_q.delete();
      m_present = 1'b0;
      m_echo    = 7'h7F;
    end
  endtask

  task automatic check_outputs();
    chk("count",   letter_count, m_q.size());
    chk("wvalid",  word_valid, m_present);
    chk("sready",  seg_ready, !m_present && !backspace && !clear);
    chk("bad",     bad_pattern, m_bad);
    chk("letters", word_letters, m_letters());
    chk("switch",  word_switch, m_switch());
    chk("dbg",     dbg_state, m_present);
`ifdef WORDLE_GUESS_ECHO_EN
    chk("echo",    echo_segment, m_echo);
`endif
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    s_letters = word_letters;
    check_outputs();
  endtask

  // driver tasks
  task automatic drive(input logic sv, input logic [6:0] pat, input logic bs,
                       input logic clr, input logic wr);
    seg_valid   = sv;
    seg_pattern = pat;
    backspace   = bs;
    clear       = clr;
    word_ready  = wr;
    step();
  endtask

  task automatic idle();
    drive(1'b0, 7'h7F, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic letter(input int i);
    drive(1'b1, pat_tab[i], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    drive(1'b0, 7'h7F, 1'b0, 1'b1, 1'b0);
  endtask

  // Called just after a negedge; reset lands between clock edges.
  task automatic do_reset();
    seg_valid = 1'b0; backspace = 1'b0; clear = 1'b0; word_ready = 1'b0;
    reset = 1'b1;
    #2;
    m_reset();
    chk("rst_letters", word_letters, 0);
    chk("rst_count", letter_count, 0);
    check_outputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_outputs();
  endtask

  initial begin
    @(negedge clock);
    do_reset();

    // THINK
    letter(19); letter(7); letter(8); letter(13); letter(10);
    chk("think_valid", word_valid, 1);
    chk("think_letters", word_letters, {5'd10, 5'd13, 5'd8, 5'd7, 5'd19});
    chk("think_sw0", word_switch[9:0], 10'b0000010010);
    repeat (3) idle();
    drive(1'b0, 7'h7F, 1'b0, 1'b0, 1'b1);
    chk("think_done", letter_count, 0);
    idle();

    // invalid pattern
    letter(0);
    drive(1'b1, 7'b1111111, 1'b0, 1'b0, 1'b0);
    chk("bad_pulse", bad_pattern, 1);
    chk("bad_cnt", letter_count, 1);
    chk("bad_slot1", word_letters[9:5], 0);
    idle();
    chk("bad_drop", bad_pattern, 0);
    do_clear();

    // CAT, backspace, R
    letter(2); letter(0); letter(19);
    chk("cat_cnt", letter_count, 3);
    drive(1'b0, 7'h7F, 1'b1, 1'b0, 1'b0);
    chk("bs_cnt", letter_count, 2);
    letter(17);
    chk("car_cnt", letter_count, 3);
    chk("car_letters", word_letters, {5'd0, 5'd0, 5'd17, 5'd0, 5'd2});
    do_clear();
    drive(1'b0, 7'h7F, 1'b1, 1'b0, 1'b0);
    chk("bs_zero", letter_count, 0);

    // held word ignores backspace and letters
    for (int i = 0; i < WL; i++) letter($urandom_range(0, 25));
    for (int i = 0; i < 10; i++)
      drive(1'b1, pat_tab[$urandom_range(0, 25)], 1'(i % 2), 1'b0, 1'b0);
    chk("hold_valid", word_valid, 1);
    drive(1'b0, 7'h7F, 1'b0, 1'b0, 1'b1);
    chk("hs_cnt", letter_count, 0);
    chk("hs_ready", seg_ready, 1);

    // clear beats backspace and accept
    letter(1); letter(4); letter(4);
    drive(1'b1, pat_tab[0], 1'b1, 1'b1, 1'b0);
    chk("clr_cnt", letter_count, 0);
    chk("clr_letters", word_letters, 0);
    idle();

    // reset mid-word
    letter(3); letter(14);
    do_reset();

`ifdef WORDLE_GUESS_ECHO_EN
    letter(6);
    chk("echo_g", echo_segment, 7'b0000100);
    drive(1'b0, 7'h7F, 1'b1, 1'b0, 1'b0);
    chk("echo_bs", echo_segment, 7'h7F);
    letter(6);
    drive(1'b1, 7'b1111111, 1'b0, 1'b0, 1'b0);
    chk("echo_keep", echo_segment, 7'b0000100);
    do_clear();
`endif

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [6:0] p;
      if ($urandom_range(0, 9) < 8) p = pat_tab[$urandom_range(0, 25)];
      else p = 7'($urandom);
      drive(1'($urandom_range(0, 9) < 7), p, 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
